csr_access_unit: RTL and testbench
==================================

CSR_ACCESS_UNIT -- requirements
Module: csr_access_unit

Interface
- REQ-001 SHALL have parameter C_XLEN, default 32, data width.
- REQ-002 SHALL have ports:
  - clk_i  in  1  clock; all state on rising edge.
  - resetb_i  in  1  reset, asynchronous, active-low.
  - clk_en_i  in  1  clock enable; low freezes all state.
  - req_valid_i  in  1  CSR instruction request.
  - req_ready_o  out  1  request accepted when valid&ready.
  - req_op_i  in  2  01 RW, 10 RS, 11 RC, 00 reserved.
  - req_addr_i  in  12  CSR address.
  - req_src_i  in  C_XLEN  rs1 value or zero-extended uimm.
  - req_src_zero_i  in  1  rs1 field/uimm is zero.
  - req_rd_zero_i  in  1  rd is x0.
  - hpl_i  in  2  current privilege level.
  - resp_valid_o  out  1  result available.
  - resp_ready_i  in  1  result consumed when valid&ready.
  - resp_rdata_o  out  C_XLEN  old CSR value, or 0 if not read.
  - resp_illegal_o  out  1  illegal-instruction flag.
  - csr_access_o  out  1  register-file access strobe.
  - csr_wr_o  out  1  1 write, 0 read.
  - csr_addr_o  out  12  register-file address.
  - csr_wdata_o  out  C_XLEN  write data.
  - csr_rdata_i  in  C_XLEN  read data, combinational, same cycle.
  - csr_illegal_i  in  1  responder rejects access, same cycle.

Function
- REQ-003 SHALL implement FSM IDLE, READ, WRITE, RESP; one request outstanding.
- REQ-004 SHALL assert req_ready_o only in IDLE and latch op, addr, src and flags on acceptance.
- REQ-005 SHALL treat op 00 as illegal: IDLE -> RESP, no CSR access.
- REQ-006 SHALL classify a write as required for RW, or for RS/RC when req_src_zero_i=0.
- REQ-007 SHALL flag illegal with no CSR access when a write is required and addr[11:10]=11 (read-only).
- REQ-008 SHALL go from IDLE to READ, except RW with rd_zero, which goes straight to WRITE with no read.
- REQ-009 READ SHALL drive access=1, wr=0 for one cycle and capture csr_rdata_i and csr_illegal_i.
- REQ-010 If csr_illegal_i is set in READ, SHALL go to RESP illegal with no write; otherwise to WRITE if a write is required, else to RESP.
- REQ-011 WRITE SHALL drive access=1, wr=1 for one cycle with wdata = src (RW), old|src (RS), or old&~src (RC).
- REQ-012 csr_illegal_i set in WRITE SHALL set resp_illegal_o; the old value is still returned.
- REQ-013 Latency, RMW, accepted in cycle N: READ N+1, WRITE N+2, resp_valid_o from N+3; a skipped state removes one cycle.
- REQ-014 SHALL hold resp_valid_o and resp data stable until resp_ready_i, then return to IDLE; a new request is accepted no earlier than the next cycle.
- REQ-015 SHALL gate csr_access_o with clk_en_i; with clk_en_i low there are no state transitions, no handshakes, and outputs hold.
- REQ-016 SHALL drive csr_addr_o, csr_wdata_o and csr_wr_o to zero whenever csr_access_o=0.

Reset
- REQ-017 resetb_i low SHALL immediately force IDLE and zero every output and register, except req_ready_o, which is 1 after release.
- REQ-018 Reset mid-operation SHALL abandon the request silently; no CSR access completes afterwards.

Configuration
- REQ-019 With CSR_PRIV_CHECK_EN defined, SHALL flag illegal with no CSR access when req_addr_i[9:8] > hpl_i; without it, SHALL perform no privilege check and SHALL ignore hpl_i.

Structure
- REQ-020 Op encodings, FSM state encodings and the read-only/privilege address field positions SHALL live in shared package csr_pkg.
- REQ-021 Write-data computation SHALL be the combinational sub-module csr_wdata_alu (op, old, src -> wdata).

Verification
- REQ-022 RS addr 0x300, src 0x8, CSR holds 0x1 -> read cycle, then write 0x9; rdata 0x1 returned at N+3.
- REQ-023 RC addr 0x300, src 0x1, holds 0xF -> write 0xE. RS with src_zero=1 -> read only, no write, resp at N+2.
- REQ-024 RW addr 0xC00 -> illegal, zero CSR accesses. RW rd_zero addr 0x340, src 0x55 -> single write 0x55, rdata 0.
- REQ-025 csr_illegal_i=1 during read -> no write, resp_illegal_o=1. resp_ready_i held low 5 cycles -> response stable, req_ready_o=0.
- REQ-026 clk_en_i low 3 cycles in READ -> access strobe low and timing shifted by 3. resetb_i low during WRITE -> IDLE, outputs zero.
- REQ-027 With CSR_PRIV_CHECK_EN, hpl_i=00 and addr 0x300 -> illegal, no access; without the macro, the same stimulus completes normally.

Source files
------------

// File: rtl/csr_pkg.sv
// Shared encodings for the CSR access unit: instruction ops, FSM states and
// the address fields used for read-only and privilege decoding.
package csr_pkg;

  typedef enum logic [1:0] {
    OP_RSVD = 2'b00,
    OP_RW   = 2'b01,
    OP_RS   = 2'b10,
    OP_RC   = 2'b11
  } csr_op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_READ  = 2'b01,
    ST_WRITE = 2'b10,
    ST_RESP  = 2'b11
  } csr_state_e;

  localparam int unsigned RO_HI   = 11;
  localparam int unsigned RO_LO   = 10;
  localparam int unsigned PRIV_HI = 9;
  localparam int unsigned PRIV_LO = 8;

  localparam logic [1:0] RO_FIELD = 2'b11;

endpackage

// File: rtl/csr_wdata_alu.sv
// Combinational CSR write-data generator: RW replaces, RS sets bits, RC clears bits.
module csr_wdata_alu #(
  parameter int unsigned C_XLEN = 32
) (
  input  logic [1:0]        op,
  input  logic [C_XLEN-1:0] old,
  input  logic [C_XLEN-1:0] src,
  output logic [C_XLEN-1:0] wdata
);
  import csr_pkg::*;

  always_comb begin
    wdata = '0;
    case (csr_op_e'(op))
      OP_RW:   wdata = src;
      OP_RS:   wdata = old | src;
      OP_RC:   wdata = old & ~src;
      default: wdata = '0;
    endcase
  end

endmodule

// File: rtl/csr_access_unit.sv
// CSR instruction sequencer: one outstanding request, optional read then write.
// Optional privilege check enabled by defining CSR_PRIV_CHECK_EN.
module csr_access_unit #(
  parameter int unsigned C_XLEN = 32
) (
  input  logic              clk_i,
  input  logic              resetb_i,
  input  logic              clk_en_i,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic [1:0]        req_op_i,
  input  logic [11:0]       req_addr_i,
  input  logic [C_XLEN-1:0] req_src_i,
  input  logic              req_src_zero_i,
  input  logic              req_rd_zero_i,
  input  logic [1:0]        hpl_i,
  output logic              resp_valid_o,
  input  logic              resp_ready_i,
  output logic [C_XLEN-1:0] resp_rdata_o,
  output logic              resp_illegal_o,
  output logic              csr_access_o,
  output logic              csr_wr_o,
  output logic [11:0]       csr_addr_o,
  output logic [C_XLEN-1:0] csr_wdata_o,
  input  logic [C_XLEN-1:0] csr_rdata_i,
  input  logic              csr_illegal_i
);
  import csr_pkg::*;

  csr_state_e        state_q, state_d;
  csr_op_e           op_q, op_d;
  logic [11:0]       addr_q, addr_d;
  logic [C_XLEN-1:0] src_q, src_d;
  logic [C_XLEN-1:0] rdata_q, rdata_d;
  logic              wr_req_q, wr_req_d;
  logic              illegal_q, illegal_d;

  logic              write_req;
  logic              ro_hit;
  logic              priv_fail;
  logic [C_XLEN-1:0] alu_wdata;

  assign write_req = (req_op_i == OP_RW) || !req_src_zero_i;
  assign ro_hit    = write_req && (req_addr_i[RO_HI:RO_LO] == RO_FIELD);

`ifdef CSR_PRIV_CHECK_EN
  assign priv_fail = req_addr_i[PRIV_HI:PRIV_LO] > hpl_i;
`else
  logic unused_hpl;
  assign unused_hpl = ^hpl_i;
  assign priv_fail  = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    addr_d    = addr_q;
    src_d     = src_q;
    rdata_d   = rdata_q;
    wr_req_d  = wr_req_q;
    illegal_d = illegal_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid_i) begin
          op_d      = csr_op_e'(req_op_i);
          addr_d    = req_addr_i;
          src_d     = req_src_i;
          wr_req_d  = write_req;
          rdata_d   = '0;
          illegal_d = 1'b0;
          if ((req_op_i == OP_RSVD) || ro_hit || priv_fail) begin
            illegal_d = 1'b1;
            state_d   = ST_RESP;
          end else if ((req_op_i == OP_RW) && req_rd_zero_i) begin
            state_d = ST_WRITE;
          end else begin
            state_d = ST_READ;
          end
        end
      end
      ST_READ: begin
        rdata_d = csr_rdata_i;
        if (csr_illegal_i) begin
          illegal_d = 1'b1;
          state_d   = ST_RESP;
        end else if (wr_req_q) begin
          state_d = ST_WRITE;
        end else begin
          state_d = ST_RESP;
        end
      end
      ST_WRITE: begin
        if (csr_illegal_i) illegal_d = 1'b1;
        state_d = ST_RESP;
      end
      ST_RESP: begin
        if (resp_ready_i) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge resetb_i) begin
    if (!resetb_i) begin
      state_q   <= ST_IDLE;
      op_q      <= OP_RSVD;
      addr_q    <= '0;
      src_q     <= '0;
      rdata_q   <= '0;
      wr_req_q  <= 1'b0;
      illegal_q <= 1'b0;
    end else if (clk_en_i) begin
      state_q   <= state_d;
      op_q      <= op_d;
      addr_q    <= addr_d;
      src_q     <= src_d;
      rdata_q   <= rdata_d;
      wr_req_q  <= wr_req_d;
      illegal_q <= illegal_d;
    end
  end

  csr_wdata_alu #(.C_XLEN(C_XLEN)) u_wdata_alu (
    .op    (op_q),
    .old   (rdata_q),
    .src   (src_q),
    .wdata (alu_wdata)
  );

  // Ready is qualified by the reset pin so it reads 0 while reset is held.
  assign req_ready_o    = resetb_i && (state_q == ST_IDLE);
  assign resp_valid_o   = (state_q == ST_RESP);
  assign resp_rdata_o   = rdata_q;
  assign resp_illegal_o = illegal_q;

  assign csr_access_o = clk_en_i && ((state_q == ST_READ) || (state_q == ST_WRITE));
  assign csr_wr_o     = csr_access_o && (state_q == ST_WRITE);
  assign csr_addr_o   = csr_access_o ? addr_q : '0;
  assign csr_wdata_o  = csr_wr_o ? alu_wdata : '0;

endmodule

// File: tb/tb_csr_access_unit.sv
// Directed, table-driven bench for csr_access_unit with a small CSR responder model.
module tb_csr_access_unit;

  logic        clk_i, resetb_i, clk_en_i;
  logic        req_valid_i, req_ready_o;
  logic [1:0]  req_op_i;
  logic [11:0] req_addr_i;
  logic [31:0] req_src_i;
  logic        req_src_zero_i, req_rd_zero_i;
  logic [1:0]  hpl_i;
  logic        resp_valid_o, resp_ready_i;
  logic [31:0] resp_rdata_o;
  logic        resp_illegal_o;
  logic        csr_access_o, csr_wr_o;
  logic [11:0] csr_addr_o;
  logic [31:0] csr_wdata_o, csr_rdata_i;
  logic        csr_illegal_i;

  csr_access_unit #(.C_XLEN(32)) dut (
    .clk_i(clk_i), .resetb_i(resetb_i), .clk_en_i(clk_en_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_op_i(req_op_i), .req_addr_i(req_addr_i), .req_src_i(req_src_i),
    .req_src_zero_i(req_src_zero_i), .req_rd_zero_i(req_rd_zero_i), .hpl_i(hpl_i),
    .resp_valid_o(resp_valid_o), .resp_ready_i(resp_ready_i),
    .resp_rdata_o(resp_rdata_o), .resp_illegal_o(resp_illegal_o),
    .csr_access_o(csr_access_o), .csr_wr_o(csr_wr_o), .csr_addr_o(csr_addr_o),
    .csr_wdata_o(csr_wdata_o), .csr_rdata_i(csr_rdata_i), .csr_illegal_i(csr_illegal_i)
  );

  always #5 clk_i = ~clk_i;

  // Responder model
  logic [31:0] csr_val, preset, last_wdata;
  logic        preset_en, ill_rd, ill_wr;
  logic [11:0] cur_addr;
  int          reads, writes, bad_addr, bad_zero;

  assign csr_rdata_i   = csr_val;
  assign csr_illegal_i = csr_access_o && (csr_wr_o ? ill_wr : ill_rd);

  always @(posedge clk_i) begin
    if (preset_en) begin
      csr_val    <= preset;
      reads      <= 0;
      writes     <= 0;
      bad_addr   <= 0;
      last_wdata <= '0;
    end else if (csr_access_o) begin
      if (csr_addr_o != cur_addr) bad_addr <= bad_addr + 1;
      if (csr_wr_o) begin
        writes     <= writes + 1;
        last_wdata <= csr_wdata_o;
        if (!csr_illegal_i) csr_val <= csr_wdata_o;
      end else begin
        reads <= reads + 1;
      end
    end
    if (!csr_access_o && (csr_addr_o != '0 || csr_wdata_o != '0 || csr_wr_o))
      bad_zero <= bad_zero + 1;
  end

  int checks, failures;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [1:0]  op;
    logic [11:0] addr;
    logic [31:0] src;
    logic        src_zero;
    logic        rd_zero;
    logic        i_rd;
    logic        i_wr;
    logic [31:0] init;
    int          exp_reads;
    int          exp_writes;
    logic [31:0] exp_wdata;
    logic [31:0] exp_rdata;
    logic        exp_ill;
    int          exp_lat;
  } vec_t;

  function automatic vec_t mk(input logic [1:0] op, input logic [11:0] addr,
                              input logic [31:0] src, input logic sz, input logic rz,
                              input logic ir, input logic iw, input logic [31:0] init,
                              input int er, input int ew, input logic [31:0] ewd,
                              input logic [31:0] erd, input logic eil, input int lat);
    vec_t v;
    v.op = op; v.addr = addr; v.src = src; v.src_zero = sz; v.rd_zero = rz;
    v.i_rd = ir; v.i_wr = iw; v.init = init; v.exp_reads = er; v.exp_writes = ew;
    v.exp_wdata = ewd; v.exp_rdata = erd; v.exp_ill = eil; v.exp_lat = lat;
    return v;
  endfunction

  // lat: cycle offset (from acceptance cycle N) at which resp_valid_o is first seen
  task automatic run(input vec_t v, input int hold, input int stall);
    int k;
    @(negedge clk_i);
    preset = v.init; ill_rd = v.i_rd; ill_wr = v.i_wr; preset_en = 1'b1;
    @(negedge clk_i);
    preset_en = 1'b0;
    cur_addr = v.addr;
    chk("req_ready_idle", {31'd0, req_ready_o}, 32'd1);
    req_valid_i = 1'b1; req_op_i = v.op; req_addr_i = v.addr; req_src_i = v.src;
    req_src_zero_i = v.src_zero; req_rd_zero_i = v.rd_zero;
    @(posedge clk_i);
    #1 req_valid_i = 1'b0;
    k = 0;
    @(negedge clk_i);
    if (stall > 0) begin
      clk_en_i = 1'b0;
      #1 chk("stall_access_low", {31'd0, csr_access_o}, 32'd0);
      repeat (stall) begin @(posedge clk_i); k++; end
      @(negedge clk_i);
      chk("stall_no_read", reads, 0);
      clk_en_i = 1'b1;
      #1 chk("stall_resume_access", {31'd0, csr_access_o}, 32'd1);
    end
    while (!resp_valid_o && k < 40) begin
      @(posedge clk_i); k++;
      @(negedge clk_i);
    end
    chk("resp_seen", {31'd0, resp_valid_o}, 32'd1);
    chk("latency", k + 1, v.exp_lat + stall);
    chk("resp_rdata", resp_rdata_o, v.exp_rdata);
    chk("resp_illegal", {31'd0, resp_illegal_o}, {31'd0, v.exp_ill});
    chk("reads", reads, v.exp_reads);
    chk("writes", writes, v.exp_writes);
    chk("wdata", last_wdata, v.exp_wdata);
    chk("addr_ok", bad_addr, 0);
    chk("ready_busy", {31'd0, req_ready_o}, 32'd0);
    repeat (hold) begin
      @(negedge clk_i);
      chk("hold_valid", {31'd0, resp_valid_o}, 32'd1);
      chk("hold_rdata", resp_rdata_o, v.exp_rdata);
      chk("hold_ready", {31'd0, req_ready_o}, 32'd0);
    end
    resp_ready_i = 1'b1;
    @(posedge clk_i);
    #1 resp_ready_i = 1'b0;
    @(negedge clk_i);
    chk("resp_done", {31'd0, resp_valid_o}, 32'd0);
    chk("ready_again", {31'd0, req_ready_o}, 32'd1);
  endtask

  vec_t vecs[12];
  vec_t pv;

  initial begin
    checks = 0; failures = 0;
    clk_i = 0; resetb_i = 0; clk_en_i = 1;
    req_valid_i = 0; req_op_i = 0; req_addr_i = 0; req_src_i = 0;
    req_src_zero_i = 0; req_rd_zero_i = 0; hpl_i = 2'b11; resp_ready_i = 0;
    preset = 0; preset_en = 0; ill_rd = 0; ill_wr = 0; cur_addr = 0; bad_zero = 0;

    repeat (2) @(negedge clk_i);
    chk("rst_ready", {31'd0, req_ready_o}, 32'd0);
    chk("rst_resp_valid", {31'd0, resp_valid_o}, 32'd0);
    chk("rst_access", {31'd0, csr_access_o}, 32'd0);
    chk("rst_rdata", resp_rdata_o, 32'd0);
    resetb_i = 1;
    #1 chk("rel_ready", {31'd0, req_ready_o}, 32'd1);

    //           op     addr    src        sz rz ir iw init        r  w  wdata       rdata       il lat
    vecs[0]  = mk(2'b10, 12'h300, 32'h8,    0, 0, 0, 0, 32'h1,      1, 1, 32'h9,      32'h1,      0, 3);
    vecs[1]  = mk(2'b11, 12'h300, 32'h1,    0, 0, 0, 0, 32'hF,      1, 1, 32'hE,      32'hF,      0, 3);
    vecs[2]  = mk(2'b10, 12'h300, 32'h0,    1, 0, 0, 0, 32'h5,      1, 0, 32'h0,      32'h5,      0, 2);
    vecs[3]  = mk(2'b01, 12'hC00, 32'h12,   0, 0, 0, 0, 32'h7,      0, 0, 32'h0,      32'h0,      1, 1);
    vecs[4]  = mk(2'b01, 12'h340, 32'h55,   0, 1, 0, 0, 32'hAA,     0, 1, 32'h55,     32'h0,      0, 2);
    vecs[5]  = mk(2'b01, 12'h341, 32'h1234, 0, 0, 0, 0, 32'hABCD,   1, 1, 32'h1234,   32'hABCD,   0, 3);
    vecs[6]  = mk(2'b00, 12'h300, 32'h3,    0, 0, 0, 0, 32'h9,      0, 0, 32'h0,      32'h0,      1, 1);
    vecs[7]  = mk(2'b11, 12'hC01, 32'h0,    1, 0, 0, 0, 32'h42,     1, 0, 32'h0,      32'h42,     0, 2);
    vecs[8]  = mk(2'b10, 12'hC00, 32'h4,    0, 0, 0, 0, 32'h1,      0, 0, 32'h0,      32'h0,      1, 1);
    vecs[9]  = mk(2'b10, 12'h300, 32'hF0,   0, 0, 0, 0, 32'h0F,     1, 1, 32'hFF,     32'h0F,     0, 3);
    vecs[10] = mk(2'b01, 12'h305, 32'h9,    0, 0, 1, 0, 32'h77,     1, 0, 32'h0,      32'h77,     1, 2);
    vecs[11] = mk(2'b10, 12'h300, 32'h2,    0, 0, 0, 1, 32'h1,      1, 1, 32'h3,      32'h1,      1, 3);

    for (int unsigned i = 0; i < 12; i++) run(vecs[i], 0, 0);

    run(vecs[0], 5, 0);
    run(vecs[0], 0, 3);

    // Reset while the write cycle is presented
    @(negedge clk_i);
    preset = 32'h1; ill_rd = 0; ill_wr = 0; preset_en = 1'b1;
    @(negedge clk_i);
    preset_en = 1'b0; cur_addr = 12'h300;
    req_valid_i = 1; req_op_i = 2'b10; req_addr_i = 12'h300; req_src_i = 32'h8;
    req_src_zero_i = 0; req_rd_zero_i = 0;
    @(posedge clk_i);
    #1 req_valid_i = 0;
    @(negedge clk_i);
    @(negedge clk_i);
    chk("pre_rst_write", {31'd0, csr_wr_o}, 32'd1);
    resetb_i = 0;
    #1;
    chk("mid_rst_access", {31'd0, csr_access_o}, 32'd0);
    chk("mid_rst_wr", {31'd0, csr_wr_o}, 32'd0);
    chk("mid_rst_addr", {20'd0, csr_addr_o}, 32'd0);
    chk("mid_rst_wdata", csr_wdata_o, 32'd0);
    chk("mid_rst_ready", {31'd0, req_ready_o}, 32'd0);
    chk("mid_rst_rdata", resp_rdata_o, 32'd0);
    @(negedge clk_i);
    resetb_i = 1;
    #1 chk("post_rst_ready", {31'd0, req_ready_o}, 32'd1);
    repeat (4) @(negedge clk_i);
    chk("post_rst_writes", writes, 0);
    chk("post_rst_reads", reads, 1);
    chk("post_rst_valid", {31'd0, resp_valid_o}, 32'd0);

    // Privilege: user level touching a machine-level address
    hpl_i = 2'b00;
`ifdef CSR_PRIV_CHECK_EN
    pv = mk(2'b01, 12'h300, 32'h5, 0, 0, 0, 0, 32'h3, 0, 0, 32'h0, 32'h0, 1, 1);
`else
    pv = mk(2'b01, 12'h300, 32'h5, 0, 0, 0, 0, 32'h3, 1, 1, 32'h5, 32'h3, 0, 3);
`endif
    run(pv, 0, 0);
    hpl_i = 2'b11;

    chk("idle_outputs_zero", bad_zero, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
